ram_write_queue: RTL and testbench
==================================

// Module: ram_write_queue
// PURPOSE
//  Write-side staging queue placed directly upstream of the multi-port VRAM/register-file wrapper.
//  - Collects up to N_IN write results per cycle from execution/writeback lanes.
//  - Holds them in program order in a circular buffer.
//  - Drains up to N_WRITE entries per cycle onto the RAM write ports.
//  - Guarantees no two same-address writes are issued in one cycle; XOR/LVT backends leave that case undefined.
// PARAMETERS
//  WIDTH    16  data word width (matches RAM WIDTH)
//  DEPTH    64  RAM depth; ADDR_WIDTH = $clog2(DEPTH)
//  N_IN      3  enqueue lanes per cycle
//  N_WRITE   3  RAM write ports driven per cycle
//  QDEPTH    8  queue entries; power of two, >= N_IN
//  N_READ    3  forwarding lookup ports (only with RWQ_FWD_EN)
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  resetn     in   1                  async active-low reset
//  in_valid   in   N_IN               lane i holds a write request
//  in_addr    in   N_IN*ADDR_WIDTH    lane i target address
//  in_data    in   N_IN*WIDTH         lane i write data
//  in_ready   out  1                  all lanes accepted this cycle when high
//  w_en       out  N_WRITE            RAM write enable per port (drives VRAM w_in.en)
//  w_addr     out  N_WRITE*ADDR_WIDTH RAM write address per port
//  w_data     out  N_WRITE*WIDTH      RAM write data per port
//  count      out  $clog2(QDEPTH)+1   occupied entries (registered)
//  fwd_addr   in   N_READ*ADDR_WIDTH  lookup address   [RWQ_FWD_EN only]
//  fwd_hit    out  N_READ             pending write found  [RWQ_FWD_EN only]
//  fwd_data   out  N_READ*WIDTH       youngest pending data [RWQ_FWD_EN only]
// BEHAVIOUR
//  Reset (async, resetn=0):
//  - head=tail=count=0; w_en=0 immediately; in_ready=1 after release.
//  - Queued entries are dropped; reset mid-drain discards them with no partial write.
//  Enqueue:
//  - in_ready = (QDEPTH - count) >= N_IN, from registered count only; the same-cycle drain is not credited.
//  - Handshake: lanes with in_valid=1 are accepted at the edge when in_ready=1.
//  - Valid lanes are compacted in ascending lane order (lane 0 oldest) into slots tail, tail+1, ...
//  - Gaps (in_valid=0) consume no slot. When in_ready=0, in_valid is ignored and nothing is written.
//  Drain:
//  - Combinational from registered state. Port k carries entry head+k when both hold:
//    - k < count;
//    - its address differs from every entry on ports 0..k-1.
//  - At the first conflict or empty slot, that port and all higher ports have w_en=0. Order is strictly preserved.
//  - head advances by the number of asserted w_en at the edge; the RAM always accepts.
//  Latency:
//  - Entry accepted at edge t appears on w_* during cycle t+1 at earliest; the RAM commits at edge t+1.
//  - An empty queue costs 1 cycle, with no same-cycle pass-through.
//  Arithmetic:
//  - head/tail are $clog2(QDEPTH) bits and wrap modulo QDEPTH.
//  - count_next = count + n_enq - n_deq, never > QDEPTH and never < 0; assert both.
//  Simultaneous enqueue and drain in one cycle is legal; entries in the same slot region are never overwritten before issue.
//  Full: count > QDEPTH-N_IN gives in_ready=0, while the drain continues. Empty: count=0 gives w_en all 0.
// CONFIGURATION
//  RWQ_FWD_EN defined:
//  - fwd_* ports exist.
//  - fwd_hit[r]=1 if any occupied entry matches fwd_addr[r].
//  - fwd_data[r] is the youngest matching entry (closest to tail).
//  - Combinational; entries issuing this cycle still count as pending.
//  - Consumers mux fwd_data over VRAM r_out to avoid stale reads during the queue delay.
//  RWQ_FWD_EN undefined: fwd_* ports and match logic are absent; all other behaviour is identical.
// TESTING
//  T1 reset:
//  - Assert resetn=0 with 5 entries queued.
//  - Expect w_en=0 at once. After release: count=0, in_ready=1, no RAM write.
//  T2 ordered drain:
//  - Cycle 0 enqueue lanes {A1:0x11,A2:0x22,A3:0x33}.
//  - Cycle 1: w_en=3'b111 in lane order. Cycle 2: count=0.
//  T3 address conflict:
//  - Enqueue {A5:0xAA, A5:0xBB, A7:0xCC}.
//  - Cycle 1: w_en=3'b001 (A5=0xAA).
//  - Cycle 2: w_en=3'b011 (A5=0xBB, A7=0xCC). RAM ends with A5=0xBB.
//  T4 full/backpressure with QDEPTH=8:
//  - Block drain by feeding conflicting addrs until count=6; expect in_ready=0.
//  - Valid lanes during that cycle are not enqueued. in_ready=1 once count<=5.
//  T5 wrap-around:
//  - Stream 3 valid lanes/cycle for 20 cycles with unique addrs.
//  - Expect every entry written exactly once, in order, across pointer wrap; count never exceeds 8.
//  T6 RWQ_FWD_EN:
//  - Queue A9:0x01 then A9:0x02; probe fwd_addr=A9.
//  - Expect fwd_hit=1, fwd_data=0x02. Probe A10: fwd_hit=0.

Source files
------------

// File: rtl/ram_write_queue_if.sv
// Bus bundle for ram_write_queue: enqueue lanes, RAM write ports, occupancy
// and, when RWQ_FWD_EN is defined, the forwarding lookup ports.
// master = producer/consumer side, slave = the queue itself.
interface ram_write_queue_if #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 64,
  parameter int N_IN    = 3,
  parameter int N_WRITE = 3,
  parameter int QDEPTH  = 8
`ifdef RWQ_FWD_EN
  ,
  parameter int N_READ  = 3
`endif
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH  = $clog2(QDEPTH) + 1;

  logic [N_IN-1:0]               in_valid;
  logic [N_IN*ADDR_WIDTH-1:0]    in_addr;
  logic [N_IN*WIDTH-1:0]         in_data;
  logic                          in_ready;
  logic [N_WRITE-1:0]            w_en;
  logic [N_WRITE*ADDR_WIDTH-1:0] w_addr;
  logic [N_WRITE*WIDTH-1:0]      w_data;
  logic [CNT_WIDTH-1:0]          count;
`ifdef RWQ_FWD_EN
  logic [N_READ*ADDR_WIDTH-1:0]  fwd_addr;
  logic [N_READ-1:0]             fwd_hit;
  logic [N_READ*WIDTH-1:0]       fwd_data;

  modport master (
    output in_valid, in_addr, in_data, fwd_addr,
    input  in_ready, w_en, w_addr, w_data, count, fwd_hit, fwd_data
  );
  modport slave (
    input  in_valid, in_addr, in_data, fwd_addr,
    output in_ready, w_en, w_addr, w_data, count, fwd_hit, fwd_data
  );
`else
  modport master (
    output in_valid, in_addr, in_data,
    input  in_ready, w_en, w_addr, w_data, count
  );
  modport slave (
    input  in_valid, in_addr, in_data,
    output in_ready, w_en, w_addr, w_data, count
  );
`endif
endinterface

// File: rtl/ram_write_queue.sv
// ram_write_queue: in-order write staging queue in front of a multi-port RAM.
// Accepts up to N_IN writes per cycle, compacted into a circular buffer, and
// drains up to N_WRITE per cycle while never issuing two writes to the same
// address in one cycle.
// Optional feature macro: RWQ_FWD_EN adds the fwd_* lookup ports that return
// the youngest pending data for an address.
module ram_write_queue #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 64,
  parameter int N_IN    = 3,
  parameter int N_WRITE = 3,
  parameter int QDEPTH  = 8
`ifdef RWQ_FWD_EN
  ,
  parameter int N_READ  = 3
`endif
) (
  input logic              clk,
  input logic              resetn,
  ram_write_queue_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int PTR_WIDTH  = $clog2(QDEPTH);
  localparam int CNT_WIDTH  = PTR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0]         q_addr [QDEPTH];
  logic [WIDTH-1:0]              q_data [QDEPTH];
  logic [PTR_WIDTH-1:0]          head;
  logic [PTR_WIDTH-1:0]          tail;
  logic [CNT_WIDTH-1:0]          count;

  logic                          in_ready;
  logic [N_IN-1:0]               lane_wr;
  logic [PTR_WIDTH-1:0]          lane_slot [N_IN];
  logic [CNT_WIDTH-1:0]          n_valid;
  logic [CNT_WIDTH-1:0]          n_enq;
  logic [CNT_WIDTH-1:0]          n_deq;
  logic                          drain_stop;
  logic [N_WRITE-1:0]            w_en;
  logic [N_WRITE*ADDR_WIDTH-1:0] w_addr;
  logic [N_WRITE*WIDTH-1:0]      w_data;
  logic [CNT_WIDTH:0]            occ_sum;

  // Room for a full set of lanes, judged on registered occupancy only
  assign in_ready = (CNT_WIDTH'(QDEPTH) - count) >= CNT_WIDTH'(N_IN);

  assign bus.in_ready = in_ready;
  assign bus.w_en     = w_en;
  assign bus.w_addr   = w_addr;
  assign bus.w_data   = w_data;
  assign bus.count    = count;

  // Compact valid lanes into consecutive slots starting at tail
  always_comb begin
    n_valid = '0;
    lane_wr = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      lane_slot[i] = tail + PTR_WIDTH'(n_valid);
      if (bus.in_valid[i]) begin
        lane_wr[i] = in_ready;
        n_valid    = n_valid + CNT_WIDTH'(1);
      end
    end
    n_enq = in_ready ? n_valid : '0;
  end

  // Issue the oldest entries in order; stop at the first empty slot or
  // address repeat so later ports never overtake an earlier blocked entry
  always_comb begin
    w_en       = '0;
    w_addr     = '0;
    w_data     = '0;
    n_deq      = '0;
    drain_stop = 1'b0;
    for (int unsigned k = 0; k < N_WRITE; k++) begin
      if (CNT_WIDTH'(k) >= count) drain_stop = 1'b1;
      for (int unsigned j = 0; j < k; j++) begin
        if (q_addr[head + PTR_WIDTH'(j)] == q_addr[head + PTR_WIDTH'(k)])
          drain_stop = 1'b1;
      end
      if (!drain_stop) begin
        w_en[k]                             = 1'b1;
        w_addr[k*ADDR_WIDTH +: ADDR_WIDTH]  = q_addr[head + PTR_WIDTH'(k)];
        w_data[k*WIDTH +: WIDTH]            = q_data[head + PTR_WIDTH'(k)];
        n_deq                               = n_deq + CNT_WIDTH'(1);
      end
    end
  end

  // Pointer and occupancy update; reset discards everything queued
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_WIDTH'(n_deq);
      tail  <= tail + PTR_WIDTH'(n_enq);
      count <= count + n_enq - n_deq;
    end
  end

  // Slot storage; contents are meaningful only between head and tail
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (lane_wr[i]) begin
        q_addr[lane_slot[i]] <= bus.in_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        q_data[lane_slot[i]] <= bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef RWQ_FWD_EN
  // Scan occupied entries oldest to youngest; the last match wins
  always_comb begin
    bus.fwd_hit  = '0;
    bus.fwd_data = '0;
    for (int unsigned r = 0; r < N_READ; r++) begin
      for (int unsigned e = 0; e < QDEPTH; e++) begin
        if (CNT_WIDTH'(e) < count &&
            q_addr[head + PTR_WIDTH'(e)] == bus.fwd_addr[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
          bus.fwd_hit[r]                = 1'b1;
          bus.fwd_data[r*WIDTH +: WIDTH] = q_data[head + PTR_WIDTH'(e)];
        end
      end
    end
  end
`endif

  assign occ_sum = {1'b0, count} + {1'b0, n_enq};

  a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
    occ_sum >= {1'b0, n_deq});
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    (occ_sum - {1'b0, n_deq}) <= (CNT_WIDTH+1)'(QDEPTH));

endmodule

// File: tb/tb_ram_write_queue.sv
// Scoreboard bench for ram_write_queue: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares every asserted write port.
module tb_ram_write_queue;
  localparam int AW = 6;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [AW+W-1:0] exp_q [$];
  logic [W-1:0]    ram [64];

  ram_write_queue_if #(.WIDTH(16), .DEPTH(64), .N_IN(3), .N_WRITE(3), .QDEPTH(8)) bus ();

  ram_write_queue #(.WIDTH(16), .DEPTH(64), .N_IN(3), .N_WRITE(3), .QDEPTH(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = '0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
  endtask

  // Present lanes for the next edge; accept is the hand-derived in_ready
  task automatic drive(input logic [2:0] v, input logic [3*AW-1:0] addrs,
                       input logic [3*W-1:0] datas, input bit accept);
    bus.in_valid = v;
    bus.in_addr  = addrs;
    bus.in_data  = datas;
    chk("in_ready", 32'(bus.in_ready), 32'(accept));
    if (accept)
      for (int i = 0; i < 3; i++)
        if (v[i]) exp_q.push_back({addrs[i*AW +: AW], datas[i*W +: W]});
  endtask

  // Monitor: every issued write must be the next expected one
  initial begin
    logic [AW+W-1:0] e;
    logic [AW-1:0]   a;
    logic [W-1:0]    d;
    logic [2:0]      en;
    forever begin
      @(negedge clk);
      en = bus.w_en;
      if (!resetn) begin
        chk("w_en_in_reset", 32'(en), 32'h0);
      end else begin
        chk("w_en_contiguous", 32'(en & (en + 3'd1)), 32'h0);
        for (int k = 0; k < 3; k++) begin
          if (en[k]) begin
            a = bus.w_addr[k*AW +: AW];
            d = bus.w_data[k*W +: W];
            for (int j = 0; j < k; j++)
              if (en[j]) chk("same_cycle_addr_distinct",
                             32'(bus.w_addr[j*AW +: AW] == a), 32'h0);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_write: got addr %0h data %0h expected none", a, d);
            end else begin
              e = exp_q.pop_front();
              chk("write_addr_data", 32'({a, d}), 32'(e));
            end
            ram[a] = d;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
`ifdef RWQ_FWD_EN
    bus.fwd_addr = '0;
`endif
    #1;
    chk("reset_w_en", 32'(bus.w_en), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("post_reset_count", 32'(bus.count), 32'h0);
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'h1);

    // T1: reset with 5 entries queued
    drive(3'b111, {6'd3, 6'd3, 6'd3}, {16'h3, 16'h2, 16'h1}, 1'b1);
    cyc();
    chk("t1_count3", 32'(bus.count), 32'h3);
    chk("t1_w_en", 32'(bus.w_en), 32'h1);
    drive(3'b111, {6'd3, 6'd3, 6'd3}, {16'h6, 16'h5, 16'h4}, 1'b1);
    cyc();
    idle();
    chk("t1_count5", 32'(bus.count), 32'h5);
    resetn = 1'b0;
    #1;
    chk("t1_w_en_async", 32'(bus.w_en), 32'h0);
    exp_q.delete();
    cyc();
    resetn = 1'b1;
    #1;
    chk("t1_count_after", 32'(bus.count), 32'h0);
    chk("t1_in_ready_after", 32'(bus.in_ready), 32'h1);
    chk("t1_w_en_after", 32'(bus.w_en), 32'h0);
    repeat (2) cyc();

    // T2: ordered drain of three distinct addresses
    drive(3'b111, {6'd3, 6'd2, 6'd1}, {16'h33, 16'h22, 16'h11}, 1'b1);
    cyc();
    idle();
    chk("t2_w_en", 32'(bus.w_en), 32'h7);
    chk("t2_count", 32'(bus.count), 32'h3);
    cyc();
    chk("t2_count_empty", 32'(bus.count), 32'h0);
    chk("t2_w_en_empty", 32'(bus.w_en), 32'h0);

    // T3: same-address conflict splits the drain
    drive(3'b111, {6'd7, 6'd5, 6'd5}, {16'hCC, 16'hBB, 16'hAA}, 1'b1);
    cyc();
    idle();
    chk("t3_w_en_c1", 32'(bus.w_en), 32'h1);
    cyc();
    chk("t3_w_en_c2", 32'(bus.w_en), 32'h3);
    chk("t3_count_c2", 32'(bus.count), 32'h2);
    cyc();
    chk("t3_count_c3", 32'(bus.count), 32'h0);
    chk("t3_ram_a5", 32'(ram[5]), 32'hBB);
    chk("t3_ram_a7", 32'(ram[7]), 32'hCC);

    // T4: backpressure; one address so only one entry drains per cycle
    drive(3'b111, {6'd20, 6'd20, 6'd20}, {16'h403, 16'h402, 16'h401}, 1'b1);
    cyc();
    chk("t4_count3", 32'(bus.count), 32'h3);
    drive(3'b111, {6'd20, 6'd20, 6'd20}, {16'h406, 16'h405, 16'h404}, 1'b1);
    cyc();
    chk("t4_count5", 32'(bus.count), 32'h5);
    drive(3'b101, {6'd20, 6'd20, 6'd20}, {16'h408, 16'hDEAD, 16'h407}, 1'b1);
    cyc();
    chk("t4_count6", 32'(bus.count), 32'h6);
    chk("t4_w_en_full", 32'(bus.w_en), 32'h1);
    drive(3'b111, {6'd20, 6'd20, 6'd20}, {16'hBAD3, 16'hBAD2, 16'hBAD1}, 1'b0);
    cyc();
    idle();
    chk("t4_count_reject", 32'(bus.count), 32'h5);
    chk("t4_in_ready_back", 32'(bus.in_ready), 32'h1);
    for (int n = 0; n < 10 && bus.count != 0; n++) cyc();
    chk("t4_drained", 32'(bus.count), 32'h0);

    // T5: sustained 3-in/3-out stream across many pointer wraps
    for (int i = 0; i < 20; i++) begin
      drive(3'b111, {6'(3*i+2), 6'(3*i+1), 6'(3*i)},
            {16'(16'h5000 + 3*i + 2), 16'(16'h5000 + 3*i + 1), 16'(16'h5000 + 3*i)}, 1'b1);
      cyc();
      chk("t5_count", 32'(bus.count), 32'h3);
      chk("t5_w_en", 32'(bus.w_en), 32'h7);
    end
    idle();
    cyc();
    chk("t5_count_end", 32'(bus.count), 32'h0);

`ifdef RWQ_FWD_EN
    // T6: forwarding returns the youngest pending data
    drive(3'b011, {6'd0, 6'd9, 6'd9}, {16'h0, 16'h02, 16'h01}, 1'b1);
    cyc();
    idle();
    bus.fwd_addr = {6'd11, 6'd10, 6'd9};
    #1;
    chk("t6_fwd_hit", 32'(bus.fwd_hit), 32'h1);
    chk("t6_fwd_data", 32'(bus.fwd_data[15:0]), 32'h2);
    cyc();
    chk("t6_fwd_hit_one_left", 32'(bus.fwd_hit), 32'h1);
    chk("t6_fwd_data_one_left", 32'(bus.fwd_data[15:0]), 32'h2);
    cyc();
    chk("t6_fwd_hit_empty", 32'(bus.fwd_hit), 32'h0);
`endif

    repeat (2) cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
